// File: rtl/packet_burst_arbiter.sv
// Packet-locked round-robin arbiter: critical-first selection, grant held until the last beat.
// Optional starvation boost enabled by defining PACKET_ARBITER_STARVATION_BOOST_EN.
module packet_burst_arbiter #(
    parameter int unsigned SINGLE_REQUEST_WIDTH_IN_BITS = 64,
    parameter int unsigned NUM_REQUEST                  = 4,
    parameter int unsigned NUM_REQUEST_LOG2             = $clog2(NUM_REQUEST),
    parameter int unsigned STARVE_THRESHOLD             = 8,
    parameter int unsigned STARVE_CNT_WIDTH             = 8
) (
    input  logic                                                clk_in,
    input  logic                                                reset_n_in,
    input  logic [SINGLE_REQUEST_WIDTH_IN_BITS*NUM_REQUEST-1:0] request_flatted_in,
    input  logic [NUM_REQUEST-1:0]                              request_valid_flatted_in,
    input  logic [NUM_REQUEST-1:0]                              request_last_flatted_in,
    input  logic [NUM_REQUEST-1:0]                              request_critical_flatted_in,
    output logic [NUM_REQUEST-1:0]                              issue_ack_out,
    output logic [SINGLE_REQUEST_WIDTH_IN_BITS-1:0]             request_out,
    output logic                                                request_last_out,
    output logic                                                request_valid_out,
    input  logic                                                issue_ack_in,
    output logic [NUM_REQUEST_LOG2-1:0]                         grant_index_out,
    output logic                                                busy_out
);

    localparam int unsigned W  = SINGLE_REQUEST_WIDTH_IN_BITS;
    localparam int unsigned N  = NUM_REQUEST;
    localparam int unsigned IW = NUM_REQUEST_LOG2;

    // Elaboration-time sanity check of the configuration.
    if (N < 2 || STARVE_THRESHOLD < 1 || STARVE_THRESHOLD > 255 ||
        64'(STARVE_THRESHOLD) >= (64'd1 << STARVE_CNT_WIDTH)) begin : g_cfg_check
        $error("packet_burst_arbiter: invalid parameter configuration");
    end

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t          state;
    logic [IW-1:0]   owner;
    logic [IW-1:0]   last_send_index;

    logic [N-1:0]    eff_crit;
    logic [N-1:0]    crit_valid;
    logic [N-1:0]    cand;
    logic [IW-1:0]   rr_idx;
    logic            rr_found;
    logic [IW-1:0]   sel_idx;
    logic            sel_valid;
    logic            sel_last;
    logic [W-1:0]    sel_data;
    logic            slot_free;
    logic            accept;
    int unsigned     rr_pos;

`ifdef PACKET_ARBITER_STARVATION_BOOST_EN
    localparam logic [STARVE_CNT_WIDTH-1:0] STARVE_MAX = STARVE_CNT_WIDTH'(STARVE_THRESHOLD);

    logic [STARVE_CNT_WIDTH-1:0] starve_cnt [N];

    // Saturating wait counters; any ack to a requester clears its count.
    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            for (int i = 0; i < int'(N); i++) starve_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < int'(N); i++) begin
                if (issue_ack_out[i])
                    starve_cnt[i] <= '0;
                else if (request_valid_flatted_in[i] && starve_cnt[i] < STARVE_MAX)
                    starve_cnt[i] <= STARVE_CNT_WIDTH'(starve_cnt[i] + 1'b1);
            end
        end
    end

    always_comb begin
        eff_crit = request_critical_flatted_in;
        for (int i = 0; i < int'(N); i++)
            if (starve_cnt[i] == STARVE_MAX) eff_crit[i] = 1'b1;
    end
`else
    assign eff_crit = request_critical_flatted_in;
`endif

    assign slot_free = ~request_valid_out | issue_ack_in;

    // Round-robin search over the critical set, falling back to all valid requesters.
    always_comb begin
        crit_valid = request_valid_flatted_in & eff_crit;
        cand       = (crit_valid != '0) ? crit_valid : request_valid_flatted_in;
        rr_idx     = '0;
        rr_found   = 1'b0;
        rr_pos     = 0;
        for (int unsigned i = 1; i <= N; i++) begin
            rr_pos = 32'(last_send_index) + i;
            if (rr_pos >= N) rr_pos = rr_pos - N;
            if (!rr_found && cand[rr_pos]) begin
                rr_found = 1'b1;
                rr_idx   = IW'(rr_pos);
            end
        end
    end

    // A locked packet bypasses selection and only its owner may proceed.
    always_comb begin
        sel_idx   = rr_idx;
        sel_valid = rr_found;
        if (state == LOCKED) begin
            sel_idx   = owner;
            sel_valid = request_valid_flatted_in[owner];
        end
        accept        = sel_valid & slot_free;
        sel_last      = request_last_flatted_in[sel_idx];
        sel_data      = request_flatted_in[sel_idx*W +: W];
        issue_ack_out = '0;
        if (accept) issue_ack_out[sel_idx] = 1'b1;
    end

    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            state             <= IDLE;
            owner             <= '0;
            last_send_index   <= IW'(N - 1);
            request_out       <= '0;
            request_last_out  <= 1'b0;
            request_valid_out <= 1'b0;
            grant_index_out   <= '0;
        end else begin
            if (accept) begin
                request_out       <= sel_data;
                request_last_out  <= sel_last;
                request_valid_out <= 1'b1;
                grant_index_out   <= sel_idx;
                if (state == IDLE) begin
                    if (sel_last) begin
                        last_send_index <= sel_idx;
                    end else begin
                        state <= LOCKED;
                        owner <= sel_idx;
                    end
                end else if (sel_last) begin
                    state           <= IDLE;
                    last_send_index <= owner;
                end
            end else if (slot_free) begin
                request_out       <= '0;
                request_last_out  <= 1'b0;
                request_valid_out <= 1'b0;
            end
        end
    end

    assign busy_out = (state == LOCKED);

endmodule

// File: tb/tb_packet_burst_arbiter.sv
// Scoreboard bench for packet_burst_arbiter: directed vectors push expected beats, a monitor checks them.
module tb_packet_burst_arbiter;

    localparam int unsigned W = 64;
    localparam int unsigned N = 4;
`ifdef PACKET_ARBITER_STARVATION_BOOST_EN
    localparam bit BOOST = 1'b1;
`else
    localparam bit BOOST = 1'b0;
`endif

    typedef struct packed {
        logic [W-1:0] data;
        logic         last;
        logic [1:0]   idx;
    } beat_t;

    logic           clk_in = 1'b0;
    logic           reset_n_in;
    logic [W-1:0]   data [N];
    logic [N-1:0]   valid, last, crit;
    logic [W*N-1:0] request_flatted_in;
    logic [N-1:0]   issue_ack_out;
    logic [W-1:0]   request_out;
    logic           request_last_out;
    logic           request_valid_out;
    logic           issue_ack_in;
    logic [1:0]     grant_index_out;
    logic           busy_out;

    beat_t sb[$];
    int    n_cmp  = 0;
    int    n_fail = 0;

    assign request_flatted_in = {data[3], data[2], data[1], data[0]};

    packet_burst_arbiter #(
        .SINGLE_REQUEST_WIDTH_IN_BITS(W),
        .NUM_REQUEST(N),
        .NUM_REQUEST_LOG2(2),
        .STARVE_THRESHOLD(4),
        .STARVE_CNT_WIDTH(8)
    ) dut (
        .clk_in(clk_in),
        .reset_n_in(reset_n_in),
        .request_flatted_in(request_flatted_in),
        .request_valid_flatted_in(valid),
        .request_last_flatted_in(last),
        .request_critical_flatted_in(crit),
        .issue_ack_out(issue_ack_out),
        .request_out(request_out),
        .request_last_out(request_last_out),
        .request_valid_out(request_valid_out),
        .issue_ack_in(issue_ack_in),
        .grant_index_out(grant_index_out),
        .busy_out(busy_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: every beat taken by the consumer must match the scoreboard head.
    always @(negedge clk_in) begin
        if (reset_n_in && request_valid_out && issue_ack_in) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_beat: got grant %0d expected no beat", grant_index_out);
            end else begin
                beat_t e;
                e = sb.pop_front();
                chk("beat_data",  request_out, e.data);
                chk("beat_last",  64'(request_last_out), 64'(e.last));
                chk("beat_grant", 64'(grant_index_out), 64'(e.idx));
            end
        end
    end

    // One cycle: check combinational ack/busy mid-cycle, queue the expected beat, advance the requester.
    task automatic step(input logic [3:0] exp_ack, input logic exp_busy, input int exp_vout, input string nm);
        int    idx;
        beat_t b;
        idx = -1;
        @(negedge clk_in);
        chk({nm, "_ack"},  64'(issue_ack_out), 64'(exp_ack));
        chk({nm, "_busy"}, 64'(busy_out), 64'(exp_busy));
        if (exp_vout >= 0) chk({nm, "_vout"}, 64'(request_valid_out), 64'(exp_vout));
        for (int i = 0; i < 4; i++) if (exp_ack[i]) idx = i;
        if (idx >= 0) begin
            b.data = data[idx];
            b.last = last[idx];
            b.idx  = 2'(idx);
            sb.push_back(b);
        end
        @(posedge clk_in);
        #1;
        if (idx >= 0) data[idx] = data[idx] + 64'd1;
    endtask

    initial begin
        logic [W-1:0] hold_v;
        logic [3:0]   exp;
        reset_n_in   = 1'b0;
        issue_ack_in = 1'b0;
        valid = '0; last = '0; crit = '0;
        for (int i = 0; i < 4; i++) data[i] = {16'hA0A0, 16'(i), 32'd0};
        repeat (2) @(posedge clk_in);
        #1;
        chk("rst_vout",  64'(request_valid_out), 64'd0);
        chk("rst_data",  request_out, 64'd0);
        chk("rst_last",  64'(request_last_out), 64'd0);
        chk("rst_grant", 64'(grant_index_out), 64'd0);
        chk("rst_busy",  64'(busy_out), 64'd0);
        reset_n_in = 1'b1;

        // Round robin over single-beat packets
        issue_ack_in = 1'b1;
        valid = 4'hF; last = 4'hF;
        step(4'b0001, 1'b0, 0, "rr0");
        step(4'b0010, 1'b0, 1, "rr1");
        step(4'b0100, 1'b0, 1, "rr2");
        step(4'b1000, 1'b0, 1, "rr3");
        step(4'b0001, 1'b0, 1, "rr4");
        valid = '0;
        step(4'b0000, 1'b0, 1, "drain1");
        step(4'b0000, 1'b0, 0, "idle1");

        // Three-beat packet from requester 1 with requester 2 waiting
        valid = 4'b0110; last = 4'b0100;
        step(4'b0010, 1'b0, -1, "pkt_b0");
        step(4'b0010, 1'b1, 1, "pkt_b1");
        last[1] = 1'b1;
        step(4'b0010, 1'b1, 1, "pkt_b2");
        valid[1] = 1'b0;
        step(4'b0100, 1'b0, 1, "pkt_next");
        valid = '0;
        step(4'b0000, 1'b0, 1, "drain2");

        // Consumer backpressure
        valid = 4'b1001; last = 4'hF;
        hold_v = data[3];
        step(4'b1000, 1'b0, 0, "hold_win");
        issue_ack_in = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step(4'b0000, 1'b0, 1, "hold");
            chk("hold_data", request_out, hold_v);
        end
        issue_ack_in = 1'b1;
        step(4'b0001, 1'b0, 1, "release");
        valid = '0;
        step(4'b0000, 1'b0, 1, "drain3");

        // Starvation of requester 3 behind a critical stream
        reset_n_in = 1'b0;
        @(posedge clk_in);
        #1;
        reset_n_in = 1'b1;
        crit = 4'b0001; valid = 4'b1001; last = 4'hF;
        for (int k = 1; k <= 8; k++) begin
            exp = (BOOST && k == 5) ? 4'b1000 : 4'b0001;
            step(exp, 1'b0, -1, "starve");
            if (exp[3]) valid[3] = 1'b0;
        end
        valid = '0; crit = '0;
        step(4'b0000, 1'b0, 1, "drain4");

        // Asynchronous reset while requester 2 holds the lock
        valid = 4'b0101; last = 4'b0001;
        step(4'b0100, 1'b0, -1, "lock_b0");
        step(4'b0100, 1'b1, 1, "lock_b1");
        #2;
        reset_n_in = 1'b0;
        #1;
        chk("arst_vout",  64'(request_valid_out), 64'd0);
        chk("arst_data",  request_out, 64'd0);
        chk("arst_last",  64'(request_last_out), 64'd0);
        chk("arst_grant", 64'(grant_index_out), 64'd0);
        chk("arst_busy",  64'(busy_out), 64'd0);
        if (sb.size() > 0) void'(sb.pop_back());
        @(posedge clk_in);
        #1;
        last[2] = 1'b1;
        reset_n_in = 1'b1;
        step(4'b0001, 1'b0, 0, "post_rst");
        valid[0] = 1'b0;
        step(4'b0100, 1'b0, 1, "post_rst2");
        valid = '0;
        step(4'b0000, 1'b0, 1, "drain5");

        // Owner stalls mid-packet while others wait
        valid = 4'b1011; last = 4'b0011;
        step(4'b1000, 1'b0, -1, "drop_b0");
        valid[3] = 1'b0;
        step(4'b0000, 1'b1, 1, "drop_w0");
        step(4'b0000, 1'b1, 0, "drop_w1");
        step(4'b0000, 1'b1, 0, "drop_w2");
        valid[3] = 1'b1; last[3] = 1'b1;
        step(4'b1000, 1'b1, 0, "drop_end");
        valid[3] = 1'b0;
        step(4'b0001, 1'b0, 1, "after0");
        valid[0] = 1'b0;
        step(4'b0010, 1'b0, 1, "after1");
        valid = '0;
        step(4'b0000, 1'b0, 1, "drain6");
        step(4'b0000, 1'b0, 0, "final_idle");

        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
